// File: rtl/fea_frame_ctrl.sv
// Frame sequencer in front of the feature core: admits one Img_Width x Img_Height frame per
// arm, holds a drain window afterwards, counts feature_flag pulses and reports completion.
module fea_frame_ctrl #(
    parameter int unsigned Img_Width    = 120,
    parameter int unsigned Img_Height   = 100,
    parameter int unsigned FLUSH_CYCLES = 2048,
    parameter int unsigned FEAT_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont_mode,
    input  logic              abort,
    input  logic [7:0]        pix_din,
    input  logic              pix_din_valid,
    input  logic              feature_flag,
    output logic [7:0]        img_din,
    output logic              img_din_valid,
    output logic [9:0]        col_cnt,
    output logic [9:0]        row_cnt,
    output logic              busy,
    output logic              frame_done,
    output logic [FEAT_W-1:0] feat_cnt,
    output logic [15:0]       frame_idx,
    output logic              err_stray,
    output logic              err_feat_sat
);

    localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [9:0] ColLast = 10'(Img_Width - 1);
    localparam logic [9:0] RowLast = 10'(Img_Height - 1);
    localparam logic [FlushW-1:0] FlushLoad = FlushW'(FLUSH_CYCLES - 1);
    localparam logic [FEAT_W-1:0] FeatMax = '1;

    typedef enum logic [2:0] {StIdle, StArmed, StActive, StFlush, StDone} state_e;

    state_e state_q, state_d;
    logic [FlushW-1:0] flush_q, flush_d;
    logic [7:0]        img_din_q, img_din_d;
    logic              valid_q;
    logic [9:0]        col_q, col_d, row_q, row_d;
    logic [FEAT_W-1:0] run_q, run_d, feat_q, feat_d;
    logic [15:0]       idx_q, idx_d;
    logic              stray_q, stray_d, sat_q, sat_d;

    logic accept, start_ok, last_pix, in_frame, pre_frame;

    // abort wins over every other event, including a pixel or a start in the same cycle
    assign accept    = pix_din_valid && !abort && (state_q == StArmed || state_q == StActive);
    assign start_ok  = start && !abort && (state_q == StIdle);
    assign pre_frame = (state_q == StIdle) || (state_q == StArmed);
    assign in_frame  = (state_q == StActive) || (state_q == StFlush) || (state_q == StDone);
    assign last_pix  = accept && (state_q == StActive) && (col_d == ColLast) && (row_d == RowLast);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

    // Next-state logic and drain countdown
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (start) state_d = StArmed;
                StArmed:  if (accept) state_d = StActive;
                StActive: begin
                    if (last_pix) begin
                        state_d = StFlush;
                        flush_d = FlushLoad;
                    end
                end
                StFlush: begin
                    if (flush_q == '0) state_d = StDone;
                    else               flush_d = flush_q - FlushW'(1);
                end
                StDone:   state_d = cont_mode ? StArmed : StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // State-decoded outputs; an abort during DONE suppresses the completion
    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone) && !abort;
    end

    // Forward path next value and pixel position of the pixel being admitted
    always_comb begin
        img_din_d = img_din_q;
        col_d     = col_q;
        row_d     = row_q;
        if (accept) begin
            img_din_d = pix_din;
            if (state_q == StArmed) begin
                col_d = '0;
                row_d = '0;
            end else if (col_q == ColLast) begin
                col_d = '0;
                row_d = row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    // Feature counting, sticky errors and per-frame result capture
    always_comb begin
        run_d   = run_q;
        stray_d = stray_q;
        sat_d   = sat_q;
        feat_d  = feat_q;
        idx_d   = idx_q;
        if (start_ok) begin
            stray_d = 1'b0;
            sat_d   = 1'b0;
        end
        if (feature_flag && pre_frame) stray_d = 1'b1;
        if (accept && state_q == StArmed) begin
            run_d = '0;
        end else if (feature_flag && in_frame) begin
            if (run_q == FeatMax) sat_d = 1'b1;
            else                  run_d = run_q + FEAT_W'(1);
        end
        // run_d already includes a flag arriving in the DONE cycle itself
        if (frame_done) begin
            feat_d = run_d;
            idx_d  = idx_q + 16'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_din_q <= '0;
            valid_q   <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            run_q     <= '0;
            feat_q    <= '0;
            idx_q     <= '0;
            stray_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            img_din_q <= img_din_d;
            valid_q   <= accept;
            col_q     <= col_d;
            row_q     <= row_d;
            run_q     <= run_d;
            feat_q    <= feat_d;
            idx_q     <= idx_d;
            stray_q   <= stray_d;
            sat_q     <= sat_d;
        end
    end

    assign img_din       = img_din_q;
    assign img_din_valid = valid_q;
    assign col_cnt       = col_q;
    assign row_cnt       = row_q;
    assign feat_cnt      = feat_q;
    assign frame_idx     = idx_q;
    assign err_stray     = stray_q;
    assign err_feat_sat  = sat_q;

endmodule
